// File: rtl/rca_nibble_seq.sv
// rca_nibble_seq: WIDTH-bit adder that adds one nibble per clock through a single shared RCA4.
// The inter-nibble carry is registered, so the only combinational carry path is four bits long.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

module rca_nibble_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
        $error("rca_nibble_seq: WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] ra, rb;
    logic             carry;
    logic [3:0]       ns;
    logic             nc;

    rca4 u_rca (
        .a   (ra[{count, 2'b00} +: 4]),
        .b   (rb[{count, 2'b00} +: 4]),
        .cin (carry),
        .s   (ns),
        .cout(nc)
    );

    assign in_ready = state == IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            ra        <= '0;
            rb        <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra    <= a;
                    rb    <= b;
                    carry <= cin;
                    count <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    sum[{count, 2'b00} +: 4] <= ns;
                    carry <= nc;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        cout      <= nc;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_nibble_seq.sv
// tb_rca_nibble_seq: table, hand-written and random checks of rca_nibble_seq against a+b+cin.
module tb_rca_nibble_seq;
    localparam int NIB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout, busy;

    logic        in_valid4 = 1'b0, in_ready4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        cin4 = 1'b0;
    logic        out_valid4, out_ready4 = 1'b0;
    logic [3:0]  sum4;
    logic        cout4, busy4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rca_nibble_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    rca_nibble_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {32'b0, c};
    endfunction

    // One full transaction: accept, wait for out_valid (optionally jamming in_valid with junk
    // to prove it is ignored), stall out_ready, then handshake.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                         input int stall, input bit noise,
                         output logic [32:0] res, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_op", {63'b0, in_ready}, 64'd1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        if (noise) begin
            a = 32'hDEAD_BEEF; b = $urandom; cin = ~tc;
        end else in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noise) chk("in_ready_low_busy", {62'b0, in_ready, busy}, 64'd1);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        res = {cout, sum};
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_result", {30'b0, out_valid, in_ready, cout, sum}, {30'b0, 2'b10, res});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", {63'b0, out_valid}, 64'd0);
        chk("result_kept", {31'b0, cout, sum}, {31'b0, res});
    endtask

    initial begin
        logic [32:0] res;
        int lat;
        vt[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vt[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        vt[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vt[5] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0};
        vt[6] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {27'b0, in_ready, out_valid, busy, cout, sum}, {27'b0, 4'b1000, 32'h0});
        chk("reset_state4", {57'b0, in_ready4, out_valid4, busy4, cout4, sum4}, {57'b0, 4'b1000, 4'h0});

        for (int i = 0; i < 7; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].cin, (i == 3) ? 5 : 0, i == 3, res, lat);
            chk($sformatf("vec%0d_result", i), {31'b0, res}, {31'b0, vt[i].co, vt[i].s});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NIB));
        end

        a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_mid_run", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_run_reset", {28'b0, in_ready, out_valid, busy, cout, sum}, {28'b0, 4'b1000, 32'h0});
        repeat (10) @(negedge clk);
        chk("no_stale_valid", {63'b0, out_valid}, 64'd0);
        do_op(32'd2, 32'd2, 1'b0, 0, 0, res, lat);
        chk("after_reset_result", {31'b0, res}, 64'd4);
        chk("after_reset_latency", 64'(lat), 64'(NIB));

        for (int n = 0; n < 1000; n++) begin
            logic [31:0] ra, rb;
            logic rc;
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res, lat);
            chk("rand_result", {31'b0, res}, {31'b0, model(ra, rb, rc)});
            chk("rand_latency", 64'(lat), 64'(NIB));
        end

        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        chk("w4_not_yet", {63'b0, out_valid4}, 64'd0);
        @(negedge clk);
        chk("w4_result", {58'b0, out_valid4, busy4, cout4, sum4}, {58'b0, 2'b10, 1'b1, 4'h0});
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("w4_idle", {62'b0, in_ready4, out_valid4}, 64'd2);
        a4 = 4'h9; b4 = 4'h4; cin4 = 1'b1; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("w4_result2", {58'b0, out_valid4, busy4, cout4, sum4}, {58'b0, 2'b10, 1'b0, 4'hE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rca_nibble_seq.md
Name: rca_nibble_seq

Overview:
Sequential multi-word adder controller. It time-shares a single instance of the team's 4-bit ripple-carry adder (RCA4) to add two WIDTH-bit operands, one nibble per clock, LSB nibble first. It sits in the partial-product accumulation path of the Vedic multiplier, where an area-lean adder is needed instead of a full-width carry chain. Valid/ready handshakes are used on both input and output.

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
NIB, WIDTH/4, number of nibble steps per operation (derived localparam, not overridable).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands/cin presented
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B+cin, low WIDTH bits
cout  output  1  carry out of MSB nibble
busy  output  1  high in RUN state

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high, and applied on rst: state=IDLE, count=0, sum=0, cout=0, out_valid=0, busy=0, internal operand/carry registers=0. in_ready is combinational from state, so it reads 1 in the cycle after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch a, b, cin into internal registers; count=0; go to RUN.
  - a, b and cin are sampled only at acceptance; later changes are ignored.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, the RCA4 inputs are operand nibble[count] of A and B plus the carry register.
  - The RCA4 sum is written to sum[4*count+3:4*count]. The carry register takes the RCA4 cout. count increments.
  - When count==NIB-1: write the last nibble, set cout from the final carry, and go to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - sum and cout hold stable until out_ready is seen high at an edge; then go to IDLE with out_valid=0.
  - sum/cout keep their last value after handshake; they are not cleared.
- Latency: out_valid rises exactly NIB cycles after the acceptance edge (8 for WIDTH=32). With out_ready held high, throughput is one operation per NIB+2 cycles. There is no back-to-back acceptance in DONE.
- in_valid while not in IDLE is ignored; no request is queued.
- out_ready while not in DONE has no effect.
- Arithmetic: {cout,sum} = a + b + cin, exact modulo 2^(WIDTH+1). The carry chain between nibbles is registered, never combinational across cycles.
- Counter width is clog2(NIB), with a minimum of 1 bit. For WIDTH=4 (NIB=1), RUN lasts one cycle.
- Reset mid-operation (RUN or DONE): abort immediately to reset values. A partial sum is never presented with out_valid=1.
- Unused: no overflow flag. Signed interpretation is left to the consumer (cout is the unsigned carry).

Test Plan:
1. Reset then idle: hold rst 2 cycles, release -> in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
2. Basic add: a=0x0000_0005, b=0x0000_0003, cin=0 accepted -> out_valid exactly 8 cycles later, sum=0x0000_0008, cout=0.
3. Full carry ripple across nibbles: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1. Also a=0xFFFF_FFFF, b=0xFFFF_FFFF, cin=1 -> sum=0xFFFF_FFFF, cout=1.
4. Output backpressure and input isolation:
   - Setup: a=0x1234_5678, b=0x1111_1111, out_ready=0 for 5 cycles after out_valid.
   - Required: sum holds 0x2345_6789, cout=0 throughout.
   - During RUN/DONE, in_valid=1 with a=0xDEAD_BEEF -> ignored. in_ready stays 0, and the result is unchanged.
5. Reset mid-RUN: accept a=0xFFFF_FFFF, b=0x1, assert rst on the 4th RUN cycle -> next cycle IDLE, out_valid=0, sum=0. A subsequent a=2, b=2 gives sum=4 after 8 cycles.
6. Random regression, plus a WIDTH=4 build:
   - 1000 random a/b/cin with random out_ready stalls, compared against the a+b+cin model.
   - WIDTH=4 build: a=0xF, b=0x1, cin=0 -> sum=0x0, cout=1, 1 cycle latency.
